// File: rtl/mcu_bus_pkg.sv
// Shared types and helpers for the MCU data-bus bridge.
// State encoding, strobe width and slot-index width.
package mcu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } state_e;

  localparam int unsigned TMO_W = 8;

  function automatic int unsigned strb_w(int unsigned dw);
    return dw / 8;
  endfunction

  // Always at least one bit so a single slave still has an index.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcu_apb_bridge_if.sv
// Core load/store port plus APB4 bus bundle.
// The slave modport is the bridge view; master is the surroundings.
interface mcu_apb_bridge_if
  import mcu_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_W     = 32
);
  localparam int unsigned SW = strb_w(DATA_W);

  logic                         req_rd;
  logic                         req_wr;
  logic [31:0]                  req_addr;
  logic [DATA_W-1:0]            req_wdata;
  logic [SW-1:0]                req_be;
  logic [DATA_W-1:0]            req_rdata;
  logic                         stall;
  logic                         done;
  logic                         err;
  logic [31:0]                  paddr;
  logic [NUM_SLAVES-1:0]        psel;
  logic                         penable;
  logic                         pwrite;
  logic [DATA_W-1:0]            pwdata;
  logic [SW-1:0]                pstrb;
  logic [NUM_SLAVES*DATA_W-1:0] prdata;
  logic [NUM_SLAVES-1:0]        pready;
  logic [NUM_SLAVES-1:0]        pslverr;

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, req_be,
    input  prdata, pready, pslverr,
    output req_rdata, stall, done, err,
    output paddr, psel, penable, pwrite, pwdata, pstrb
  );

  modport master (
    output req_rd, req_wr, req_addr, req_wdata, req_be,
    output prdata, pready, pslverr,
    input  req_rdata, stall, done, err,
    input  paddr, psel, penable, pwrite, pwdata, pstrb
  );

endinterface

// File: rtl/mcu_apb_decoder.sv
// Address window decoder: hit, slot index, slot populated.
// Window spans 2**idx_w slots even when fewer are populated.
module mcu_apb_decoder
  import mcu_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned SPAN_LOG2  = 12,
  localparam int unsigned IW        = idx_w(NUM_SLAVES)
) (
  input  logic          valid_i,
  input  logic [31:0]   addr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o,
  output logic          idx_valid_o
);
  localparam int unsigned  WIN_LSB = SPAN_LOG2 + IW;
  localparam logic [IW:0]  NS      = (IW+1)'(NUM_SLAVES);

  assign hit_o = valid_i &&
    (addr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign idx_o       = addr_i[SPAN_LOG2 +: IW];
  assign idx_valid_o = ({1'b0, idx_o} < NS);

endmodule

// File: rtl/mcu_apb_bridge.sv
// Core load/store to APB4 bridge with wait-state stall,
// slave error capture and ACCESS-phase timeout.
module mcu_apb_bridge
  import mcu_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_W     = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned SPAN_LOG2  = 12,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic clk,
  input logic rst,
  mcu_apb_bridge_if.slave bus
);
  localparam int unsigned IW = idx_w(NUM_SLAVES);
  localparam int unsigned SW = strb_w(DATA_W);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [31:0]           paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [TMO_W-1:0]      cnt_q, cnt_d;
  logic                  stall;

  logic                  hit;
  logic [IW-1:0]         dec_idx;
  logic                  dec_ok;
  logic [NUM_SLAVES-1:0] dec_oh;
  logic [DATA_W-1:0]     slot_rdata;
  logic                  slot_rdy;
  logic                  slot_err;

  mcu_apb_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .SPAN_LOG2  (SPAN_LOG2)
  ) u_dec (
    .valid_i     (bus.req_rd | bus.req_wr),
    .addr_i      (bus.req_addr),
    .hit_o       (hit),
    .idx_o       (dec_idx),
    .idx_valid_o (dec_ok)
  );

  // One-hot select for the decoded slot, and mux of the latched slot.
  always_comb begin
    dec_oh     = '0;
    slot_rdata = '0;
    slot_rdy   = 1'b0;
    slot_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dec_idx == IW'(i)) dec_oh[i] = 1'b1;
      if (idx_q == IW'(i)) begin
        slot_rdata = bus.prdata[i*DATA_W +: DATA_W];
        slot_rdy   = bus.pready[i];
        slot_err   = bus.pslverr[i];
      end
    end
  end

  // Next-state, APB phase control and completion outputs.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    idx_d     = idx_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    stall     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          stall = 1'b1;
          if (dec_ok) begin
            paddr_d  = bus.req_addr;
            pwrite_d = bus.req_wr;
            pwdata_d = bus.req_wdata;
            pstrb_d  = bus.req_wr ? bus.req_be : '0;
            idx_d    = dec_idx;
            psel_d   = dec_oh;
            cnt_d    = '0;
            state_d  = ST_SETUP;
          end else begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_SETUP: begin
        stall     = 1'b1;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (slot_rdy) begin
          done_d    = 1'b1;
          err_d     = slot_err;
          rdata_d   = (!pwrite_q && !slot_err) ? slot_rdata : '0;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          done_d    = 1'b1;
          err_d     = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      idx_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      idx_q     <= idx_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.req_rdata = rdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;

endmodule

// File: tb/tb_mcu_apb_bridge.sv
// Bench for mcu_apb_bridge: directed corner cases plus
// random transfers checked against a transaction-level model.
module tb_mcu_apb_bridge;
  localparam int          NS   = 4;
  localparam int          TMO  = 255;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] WEND = 32'h1000_4000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mcu_apb_bridge_if #(.NUM_SLAVES(4), .DATA_W(32)) bus ();
  mcu_apb_bridge_if #(.NUM_SLAVES(3), .DATA_W(32)) bus3 ();

  mcu_apb_bridge #(
    .NUM_SLAVES(4), .DATA_W(32), .BASE_ADDR(BASE),
    .SPAN_LOG2(12), .TIMEOUT(TMO)
  ) u_dut (.clk(clk), .rst(rst), .bus(bus));

  mcu_apb_bridge #(
    .NUM_SLAVES(3), .DATA_W(32), .BASE_ADDR(BASE),
    .SPAN_LOG2(12), .TIMEOUT(TMO)
  ) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] slot_data [NS];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_prdata();
    bus.prdata = {slot_data[3], slot_data[2], slot_data[1], slot_data[0]};
  endtask

  // One core transfer; expectations come from address arithmetic and
  // the responder's wait count, not from DUT state.
  task automatic run_txn(input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int waits,
                         input bit serr);
    bit          hit;
    int          slot;
    int          exp_done;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          acc = 0;
    int          stalls = 0;
    int          done_at = -1;
    bit          psel_seen = 1'b0;
    bit          stable_ok = 1'b1;
    bit          setup_ok = 1'b1;
    logic        got_err = 1'b0;
    logic [31:0] got_rd = '0;
    hit  = (rd || wr) && (addr >= BASE) && (addr < WEND);
    slot = int'((addr - BASE) >> 12);
    if (waits >= TMO) begin
      exp_done = 2 + TMO;
      exp_err  = 1'b1;
      exp_rd   = '0;
    end else begin
      exp_done = 3 + waits;
      exp_err  = serr;
      exp_rd   = (!wr && !serr) ? slot_data[slot] : '0;
    end
    load_prdata();
    @(negedge clk);
    bus.req_rd    = rd;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    for (int c = 0; c < 400; c++) begin
      bus.pready  = 4'($urandom);
      bus.pslverr = 4'($urandom);
      if (hit) begin
        bus.pready[slot]  = bus.penable && (acc >= waits);
        bus.pslverr[slot] = serr;
      end
      #1;
      if (bus.stall) stalls++;
      if (bus.psel != '0) begin
        psel_seen = 1'b1;
        if (bus.paddr !== addr || bus.pwrite !== wr ||
            bus.pstrb !== (wr ? be : 4'h0) ||
            (wr && bus.pwdata !== wdata))
          stable_ok = 1'b0;
      end
      if (hit && c == 1)
        setup_ok = (bus.psel === 4'(1 << slot)) && !bus.penable;
      if (bus.penable) acc++;
      if (bus.done) begin
        done_at = c;
        got_err = bus.err;
        got_rd  = bus.req_rdata;
        break;
      end
      if (!hit && c == 3) break;
      @(negedge clk);
    end
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
    if (hit) begin
      chk("done_cycle", 64'(done_at), 64'(exp_done));
      chk("err", 64'(got_err), 64'(exp_err));
      chk("rdata", 64'(got_rd), 64'(exp_rd));
      chk("stall_cycles", 64'(stalls), 64'(exp_done));
      chk("setup_phase", 64'(setup_ok), 64'd1);
      chk("apb_stable", 64'(stable_ok), 64'd1);
      @(negedge clk);
      #1;
      chk("after_done", 64'({bus.done, bus.psel}), 64'd0);
    end else begin
      chk("miss_stall", 64'(stalls), 64'd0);
      chk("miss_psel", 64'(psel_seen), 64'd0);
      chk("miss_done", 64'(done_at), 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  initial begin
    bus.req_rd = 1'b0;  bus.req_wr = 1'b0;
    bus.req_addr = '0;  bus.req_wdata = '0;  bus.req_be = '0;
    bus.prdata = '0;    bus.pready = '0;     bus.pslverr = '0;
    bus3.req_rd = 1'b0; bus3.req_wr = 1'b0;
    bus3.req_addr = '0; bus3.req_wdata = '0; bus3.req_be = '0;
    bus3.prdata = '0;   bus3.pready = '0;    bus3.pslverr = '0;
    for (int i = 0; i < NS; i++) slot_data[i] = $urandom;

    #12;
    chk("reset_outs", 64'({bus.psel, bus.penable, bus.done, bus.err}), 64'd0);
    chk("reset_data", 64'({bus.req_rdata, bus.paddr}), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    slot_data[1] = 32'hCAFE_F00D;
    run_txn(1'b1, 1'b0, 32'h1000_1004, 32'h0, 4'h0, 0, 1'b0);
    run_txn(1'b0, 1'b1, 32'h1000_3000, 32'h1234_5678, 4'b0011, 5, 1'b0);
    run_txn(1'b1, 1'b0, 32'h1000_2008, 32'h0, 4'h0, 2, 1'b1);
    run_txn(1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'h0, 1000, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'h0, 0, 1'b0);
    run_txn(1'b0, 1'b1, WEND, 32'h5555_AAAA, 4'hF, 0, 1'b0);
    run_txn(1'b1, 1'b1, 32'h1000_3FFC, 32'hDEAD_BEEF, 4'b1001, 1, 1'b0);

    // Slot 3 is unpopulated when only three slaves exist.
    @(negedge clk);
    bus3.req_rd = 1'b1;
    bus3.req_addr = 32'h1000_3010;
    #1;
    chk("unpop_stall", 64'({bus3.stall, bus3.psel}), 64'h8);
    @(negedge clk);
    #1;
    chk("unpop_done", 64'({bus3.done, bus3.err}), 64'h3);
    chk("unpop_outs", 64'({bus3.psel, bus3.req_rdata}), 64'd0);
    bus3.req_rd = 1'b0;
    @(negedge clk);
    #1;
    chk("unpop_after", 64'(bus3.done), 64'd0);

    // Reset while a slave holds off ready.
    @(negedge clk);
    bus.req_rd = 1'b1;
    bus.req_addr = 32'h1000_0020;
    bus.pready = '0;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_rst_access", 64'({bus.psel, bus.penable}), 64'h3);
    rst = 1'b0;
    bus.req_rd = 1'b0;
    #1;
    chk("rst_drop", 64'({bus.psel, bus.penable, bus.done}), 64'd0);
    begin
      bit saw_done = 1'b0;
      repeat (3) begin
        @(negedge clk);
        #1;
        if (bus.done) saw_done = 1'b1;
      end
      chk("rst_no_done", 64'(saw_done), 64'd0);
    end
    rst = 1'b1;
    slot_data[0] = 32'h0BAD_F00D;
    run_txn(1'b1, 1'b0, 32'h1000_0020, 32'h0, 4'h0, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int          kind;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      for (int i = 0; i < NS; i++) slot_data[i] = $urandom;
      kind = int'($urandom_range(0, 9));
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr && kind != 0) rd = 1'b1;
      if (kind == 0)
        addr = ($urandom & 32'h0FFF_FFFC) | (kind[0] ? 32'h2000_0000 : 32'h0);
      else
        addr = BASE + 32'($urandom_range(0, 3) << 12) +
               32'($urandom_range(0, 1023) << 2);
      run_txn(rd, wr, addr, $urandom, 4'($urandom),
              int'($urandom_range(0, 6)), ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
